// File: rtl/mem_port_scheduler.sv
// mem_port_scheduler: round-robin packer of client reads/writes onto a multi-port register file.
// Define MEM_SCHED_STALL_CNT_EN to add the saturating stall_cnt output.
module mem_port_scheduler #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 4,
  parameter int NUM_WRITE_PORTS = 4,
  parameter int NUM_READ_PORTS  = 2,
  parameter int NUM_CLIENTS     = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_CLIENTS-1:0]                req_valid,
  input  logic [NUM_CLIENTS-1:0]                req_we,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0]     req_wdata,
  output logic [NUM_CLIENTS-1:0]                req_ready,
  output logic [NUM_CLIENTS-1:0]                rsp_valid,
  output logic [NUM_CLIENTS*DATA_WIDTH-1:0]     rsp_rdata,
  output logic [NUM_WRITE_PORTS-1:0]            mem_we,
  output logic [NUM_WRITE_PORTS*ADDR_WIDTH-1:0] mem_waddr,
  output logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] mem_wdata,
  output logic [NUM_READ_PORTS-1:0]             mem_re,
  output logic [NUM_READ_PORTS*ADDR_WIDTH-1:0]  mem_raddr,
  input  logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  mem_rdata
`ifdef MEM_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]                           stall_cnt
`endif
);
  localparam int CID_WIDTH = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  logic [CID_WIDTH-1:0]                      rr_ptr;
  logic [NUM_READ_PORTS-1:0]                 rd_act;
  logic [NUM_READ_PORTS-1:0][CID_WIDTH-1:0]  rd_cid, rd_cid_nxt;
  int c, first, wcnt, rcnt;
  logic hit;
  // Granted writes are already packed into mem_we/mem_waddr, so the conflict check scans those.
  always_comb begin
    req_ready  = '0;
    mem_we     = '0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    mem_re     = '0;
    mem_raddr  = '0;
    rd_cid_nxt = '0;
    c = 0;
    first = -1;
    wcnt = 0;
    rcnt = 0;
    hit = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      c = (int'(rr_ptr) + i) % NUM_CLIENTS;
      hit = 1'b0;
      for (int j = 0; j < NUM_WRITE_PORTS; j++)
        hit = hit | (mem_we[j] && mem_waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == req_addr[c*ADDR_WIDTH +: ADDR_WIDTH]);
      if (req_valid[c] && req_we[c] && wcnt < NUM_WRITE_PORTS && !hit) begin
        req_ready[c] = 1'b1;
        mem_we[wcnt] = 1'b1;
        mem_waddr[wcnt*ADDR_WIDTH +: ADDR_WIDTH] = req_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata[wcnt*DATA_WIDTH +: DATA_WIDTH] = req_wdata[c*DATA_WIDTH +: DATA_WIDTH];
        wcnt++;
      end else if (req_valid[c] && !req_we[c] && rcnt < NUM_READ_PORTS) begin
        req_ready[c] = 1'b1;
        mem_re[rcnt] = 1'b1;
        mem_raddr[rcnt*ADDR_WIDTH +: ADDR_WIDTH] = req_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
        rd_cid_nxt[rcnt] = CID_WIDTH'(c);
        rcnt++;
      end
      if (req_ready[c] && first < 0) first = c;
    end
    if (!rst_n) begin
      req_ready = '0;
      mem_we    = '0;
      mem_waddr = '0;
      mem_wdata = '0;
      mem_re    = '0;
      mem_raddr = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      rd_act <= '0;
      rd_cid <= '0;
    end else begin
      rr_ptr <= (first >= 0) ? CID_WIDTH'((first + 1) % NUM_CLIENTS) : rr_ptr;
      rd_act <= mem_re;
      rd_cid <= rd_cid_nxt;
    end
  end
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int k = 0; k < NUM_READ_PORTS; k++)
      if (rd_act[k] && rst_n) begin
        rsp_valid[rd_cid[k]] = 1'b1;
        rsp_rdata[rd_cid[k]*DATA_WIDTH +: DATA_WIDTH] = mem_rdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
  end
`ifdef MEM_SCHED_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt <= '0;
    else if (|(req_valid & ~req_ready) && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: doc/mem_port_scheduler.md
Name: mem_port_scheduler

Overview:
- Shares one multi-port register-file memory (NUM_WRITE_PORTS write ports, NUM_READ_PORTS read ports, 1-cycle registered read) among NUM_CLIENTS requesters.
- Each cycle it grants up to NUM_WRITE_PORTS writes and NUM_READ_PORTS reads in round-robin order, and packs them onto the memory's flat port vectors.
- It blocks same-cycle write-write address conflicts and routes read data back to the issuing client one cycle after grant.

Parameters:
- DATA_WIDTH, 8, memory word width.
- ADDR_WIDTH, 4, memory address width (depth 2**ADDR_WIDTH).
- NUM_WRITE_PORTS, 4, memory write ports.
- NUM_READ_PORTS, 2, memory read ports.
- NUM_CLIENTS, 4, requesters; must be ≥ 1.
- CID_WIDTH, $clog2(NUM_CLIENTS) (min 1), client index width; derived, not to be overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_CLIENTS  per-client request valid.
- req_we  in  NUM_CLIENTS  1 = write, 0 = read.
- req_addr  in  NUM_CLIENTS*ADDR_WIDTH  flat, client c at [c*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_CLIENTS*DATA_WIDTH  flat, client c at [c*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_CLIENTS  grant; a transfer occurs when valid & ready.
- rsp_valid  out  NUM_CLIENTS  read data valid for client c.
- rsp_rdata  out  NUM_CLIENTS*DATA_WIDTH  flat read data per client.
- mem_we  out  NUM_WRITE_PORTS  to memory write enables.
- mem_waddr  out  NUM_WRITE_PORTS*ADDR_WIDTH  to memory.
- mem_wdata  out  NUM_WRITE_PORTS*DATA_WIDTH  to memory.
- mem_re  out  NUM_READ_PORTS  to memory read enables.
- mem_raddr  out  NUM_READ_PORTS*ADDR_WIDTH  to memory.
- mem_rdata  in  NUM_READ_PORTS*DATA_WIDTH  from memory; valid the cycle after mem_re.

Behaviour:
- Arbitration is combinational from req_* and rr_ptr.
  - Scan order is clients rr_ptr, rr_ptr+1, … mod NUM_CLIENTS.
  - A valid write is granted if a write slot remains and no earlier-granted write this cycle has the same address.
  - A valid read is granted if a read slot remains.
  - Reads and writes use independent slot pools.
- Packing: the k-th granted write (scan order) drives write port k; the k-th granted read drives read port k.
  - Unused ports have we/re = 0, and their addr/data are driven 0.
- Same-address write conflict: the later client in scan order is held (ready = 0) and retries the next cycle. It is never dropped.
- Read and write to the same address granted in one cycle: the read returns the pre-write value, because the memory updates at the same edge.
- rr_ptr (CID_WIDTH register):
  - If any grant occurs, rr_ptr <= (index of first granted client in scan order + 1) mod NUM_CLIENTS.
  - Otherwise it holds.
  - This guarantees each continuously-valid client is granted within NUM_CLIENTS cycles.
- Response tracking:
  - Per read port, the scheduler registers rd_act (1 bit) and rd_cid (CID_WIDTH) at each grant.
  - In the next cycle, rsp_valid[rd_cid[k]] = rd_act[k], and rsp_rdata for that client = mem_rdata port k slice.
  - rsp_rdata for a client with rsp_valid = 0 is 0.
  - Read latency from handshake to rsp_valid is exactly 1 cycle.
  - Responses have no backpressure; clients must accept them.
- Reset (rst_n = 0 at a rising edge):
  - rr_ptr = 0, rd_act = 0, rd_cid = 0.
  - While rst_n is low: req_ready, mem_we and mem_re are forced 0, and rsp_valid = 0.
  - A read granted in the cycle before reset asserts has its response dropped.
- Edge cases:
  - A client with req_valid low is never granted, and a deasserted valid is simply skipped.
  - NUM_CLIENTS ≤ port count is legal; all requests are granted unless they conflict.

Optional Feature:
- Macro: MEM_SCHED_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0].
  - Increments by 1 on each cycle (rst_n high) where any client has req_valid & !req_ready.
  - Saturates at 16'hFFFF and resets to 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst_n low 2 cycles with all req_valid = 1 → req_ready = 0, mem_we = 0, mem_re = 0, rsp_valid = 0. Release → first grants start from client 0.
- Four writes, distinct addresses: client0..3 write addr 1,2,3,4, data 8'h11..8'h44 in one cycle → all ready; mem_we = 4'b1111, port k = client k; next cycle reads of addr 1..4 return 8'h11..8'h44.
- Write conflict: clients 0 and 2 both write addr 5 (8'hAA, 8'hBB), rr_ptr = 0 → cycle 1 grants client0 only; cycle 2 grants client2; final mem[5] = 8'hBB.
- Read oversubscription: 4 clients read addr 0..3 continuously, 2 read ports → 2 grants per cycle, rotating; every client receives rsp_valid exactly 1 cycle after its handshake with correct data; no client waits > 4 cycles.
- Read/write same address same cycle: mem[7] = 8'h01; client1 writes 7 ← 8'h02 and client3 reads 7 → client3 gets 8'h01; a re-read gets 8'h02.
- With MEM_SCHED_STALL_CNT_EN: the conflict scenario, held 3 cycles → stall_cnt = 3; force 70000 stall cycles → stall_cnt = 16'hFFFF.
